imem_loader: RTL and testbench

Program loader for the instruction memory write port. Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes each word to consecutive word addresses starting at 0. Holds the pipeline in stall while loading and stops early on the halt opcode, so test programs can be streamed in rather than hard-coded.

---
 rtl/imem_loader_if.sv | 34 +++
 rtl/imem_loader.sv | 114 +++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Bus between the program loader and its environment: byte stream in,
// instruction-memory write port and load status out.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  // Handshake: a byte transfers on each rising clk edge where byte_valid and
  // byte_ready are both high; the source holds byte_in stable while
  // byte_valid is high and ready is low, and readiness never depends on valid.
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_stall;
  logic [ADDR_W:0]   words_loaded;
  logic              done;
  logic              err;
  logic [1:0]        fsm_state;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_stall,
    input  words_loaded, done, err, fsm_state
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata, cpu_stall,
    output words_loaded, done, err, fsm_state
  );
endinterface

// File: rtl/imem_loader.sv
// Streams a little-endian byte sequence into instruction memory one 32-bit
// word at a time, stalling the CPU until the count is reached or a halt word.
module imem_loader #(
  parameter int         DEPTH       = 1024,
  parameter int         ADDR_W      = 10,
  parameter logic [6:0] HALT_OPCODE = 7'b1111111
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        byte_idx;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   loaded;
  logic [ADDR_W:0]   count;
  logic              err_q;

  logic count_zero;
  logic count_bad;
  logic byte_fire;
  logic last_word;

  always_comb begin
    count_zero = (bus.word_count == '0);
    count_bad  = (bus.word_count > DEPTH_W);
    byte_fire  = (state == LOAD) && bus.byte_valid;
    // The halt word is still written; it only ends the stream afterwards.
    last_word  = ((loaded + 1'b1) == count) || (wdata[6:0] == HALT_OPCODE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          if (count_zero || count_bad) state_nxt = DONE;
          else                         state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (byte_fire && (byte_idx == 2'd3)) state_nxt = WRITE;
      end
      WRITE: begin
        if (last_word) state_nxt = DONE;
        else           state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      wdata    <= '0;
      addr     <= '0;
      loaded   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            byte_idx <= '0;
            addr     <= '0;
            loaded   <= '0;
            count    <= bus.word_count;
            err_q    <= count_bad;
          end
        end
        LOAD: begin
          // byte_idx wraps 3 -> 0, so the next word starts at byte 0.
          if (byte_fire) begin
            wdata[{byte_idx, 3'b000} +: 8] <= bus.byte_in;
            byte_idx                       <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          loaded <= loaded + 1'b1;
          if (!last_word) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready   = (state == LOAD);
  assign bus.mem_we       = (state == WRITE);
  assign bus.cpu_stall    = (state == LOAD) || (state == WRITE);
  assign bus.done         = (state == DONE);
  assign bus.err          = err_q;
  assign bus.mem_addr     = addr;
  assign bus.mem_wdata    = wdata;
  assign bus.words_loaded = loaded;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized loads of imem_loader checked against a word-level
// model of which words must land at which addresses.
module tb_imem_loader;

  localparam int         DEPTH  = 1024;
  localparam int         ADDR_W = 10;
  localparam logic [6:0] HALT   = 7'h7F;

  logic clk;
  logic rst;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .HALT_OPCODE(HALT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] last_exp;
  logic [31:0]        wq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every write must match the next word the model predicted.
  always @(negedge clk) begin
    if (!rst && bus.mem_we === 1'b1) begin
      logic               pending;
      logic [ADDR_W+31:0] e;
      pending = (exp_q.size() > 0);
      check("write_pending", pending, 1'b1);
      check("we_ready_low", bus.byte_ready, 1'b0);
      check("we_stall", bus.cpu_stall, 1'b1);
      if (pending) begin
        e = exp_q.pop_front();
        check("mem_addr", bus.mem_addr, e[ADDR_W+31:32]);
        check("mem_wdata", bus.mem_wdata, e[31:0]);
      end
    end
  end

  // Model: words 0.. are written in order until count is reached or a word
  // whose low 7 bits are the halt opcode has been written.
  task automatic model_load(input int count, output int n);
    n = 0;
    if (count == 0 || count > DEPTH) return;
    for (int i = 0; i < count && i < wq.size(); i++) begin
      last_exp = {ADDR_W'(i), wq[i]};
      exp_q.push_back(last_exp);
      n++;
      if (wq[i][6:0] == HALT) break;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int limit, output bit ok);
    ok = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int t = 0; t < limit; t++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    bus.byte_valid = 1'b0;
    if (!ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int count);
    bus.start      = 1'b1;
    bus.word_count = (ADDR_W + 1)'(count);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, bus.byte_ready, 1'b0);
    check({tag, "_mem_we"}, bus.mem_we, 1'b0);
    check({tag, "_mem_addr"}, bus.mem_addr, '0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    check({tag, "_cpu_stall"}, bus.cpu_stall, 1'b0);
    check({tag, "_words_loaded"}, bus.words_loaded, '0);
    check({tag, "_done"}, bus.done, 1'b0);
    check({tag, "_err"}, bus.err, 1'b0);
  endtask

  // Full load of the words in wq; gaps are idle cycles before bytes 1..3.
  task automatic run_load(input int count, input int gmin, input int gmax, input bit poke);
    int n;
    bit ok;
    bit bad;
    bad = (count > DEPTH);
    model_load(count, n);
    pulse_start(count);
    @(negedge clk);
    if (n == 0) begin
      check("bad_done", bus.done, 1'b1);
      check("bad_err", bus.err, bad);
      check("bad_stall", bus.cpu_stall, 1'b0);
      check("bad_ready", bus.byte_ready, 1'b0);
      check("bad_loaded", bus.words_loaded, '0);
      @(posedge clk);
      #1;
      return;
    end
    check("load_stall", bus.cpu_stall, 1'b1);
    check("load_ready", bus.byte_ready, 1'b1);
    check("load_err", bus.err, 1'b0);
    @(posedge clk);
    #1;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin
          int gap;
          gap = $urandom_range(gmax, gmin);
          for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check("gap_ready", bus.byte_ready, 1'b1);
            @(posedge clk);
            #1;
          end
          if (poke && w == 0 && k == 2) pulse_start(1);
        end
        send_byte(wq[w][8*k +: 8], 20, ok);
        check("byte_accepted", ok, 1'b1);
      end
    end
    @(negedge clk);
    check("last_we", bus.mem_we, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("end_done", bus.done, 1'b1);
    check("end_stall", bus.cpu_stall, 1'b0);
    check("end_err", bus.err, 1'b0);
    check("end_ready", bus.byte_ready, 1'b0);
    check("end_loaded", bus.words_loaded, (ADDR_W + 1)'(n));
    check("end_queue_empty", exp_q.size(), 0);
    check("hold_addr", bus.mem_addr, last_exp[ADDR_W+31:32]);
    check("hold_wdata", bus.mem_wdata, last_exp[31:0]);
    @(posedge clk);
    #1;
    if (n < count) begin
      send_byte(8'hAA, 4, ok);
      check("after_halt_no_accept", ok, 1'b0);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[6:0] == HALT) w[0] = 1'b0;
    return w;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single word, back-to-back bytes
    wq = '{32'h002080B3};
    run_load(1, 0, 0, 1'b0);

    // three words, one idle cycle between bytes
    wq = '{rand_word(), rand_word(), rand_word()};
    run_load(3, 1, 1, 1'b0);

    // early halt on the second word
    wq = '{32'h002080B3, 32'h0190257F, rand_word(), rand_word(), rand_word()};
    run_load(5, 0, 0, 1'b0);

    // bad counts, then a normal load clears err
    wq = '{rand_word()};
    run_load(0, 0, 0, 1'b0);
    run_load(1025, 0, 0, 1'b0);
    run_load(1, 0, 1, 1'b0);

    // reset after two bytes of a word
    wq = '{32'hDEADBEEF};
    pulse_start(1);
    send_byte(8'hEF, 20, ok);
    check("pre_reset_b0", ok, 1'b1);
    send_byte(8'hBE, 20, ok);
    check("pre_reset_b1", ok, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    wq = '{32'h12345613};
    run_load(1, 0, 0, 1'b0);

    // start pulsed during LOAD is ignored
    wq = '{rand_word(), rand_word(), rand_word()};
    run_load(3, 0, 1, 1'b1);

    // randomized loads, sometimes with a halt word
    for (int r = 0; r < 10; r++) begin
      int cnt;
      cnt = $urandom_range(6, 1);
      wq.delete();
      for (int i = 0; i < cnt; i++) wq.push_back(rand_word());
      if ($urandom_range(3, 0) == 0) begin
        int h;
        h = $urandom_range(cnt - 1, 0);
        wq[h][6:0] = HALT;
      end
      run_load(cnt, 0, 2, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
